// File: rtl/dm_be_ram.sv
// dm_be_ram: word-organised MEM-stage data memory with byte-lane writes.
//
// Store size and address low bits become byte enables and replicated write
// data. Each 32-bit word is kept as four independent 8-bit lanes so that a
// partial store only touches its own lanes. The read is registered, and the
// load op and byte offset are registered alongside it. The load extender in
// WB then sees a raw word, the op that asked for it and the offset it needs.
//
// Optional build macro: DM_CLEAR_EN
//   defined   - after reset a counter walks every word and writes zero to it.
//               busy is held high until the walk finishes.
//   undefined - no counter is built, busy is tied low and the memory contents
//               after reset are whatever the array powered up with.
module dm_be_ram #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [1:0]  st_op,
    input  logic        ld_en,
    input  logic [2:0]  ld_op,
    output logic [31:0] rd_data,
    output logic [2:0]  ext_op,
    output logic [1:0]  ext_a,
    output logic        ld_valid,
    output logic        align_err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SW   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SB   = 2'b11;

    localparam logic [2:0] LD_LW   = 3'b000;
    localparam logic [2:0] LD_LHU  = 3'b011;
    localparam logic [2:0] LD_LH   = 3'b100;

    // Address split. Bits above the word index are deliberately ignored.
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_off;
    logic              unused_addr_bits;

    assign word_idx         = addr[ADDR_W+1:2];
    assign byte_off         = addr[1:0];
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    // Store decode: lane enables, lane-replicated data and misalignment.
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic        st_mis;

    // Decode the store size into lane enables and lane-replicated data.
    always_comb begin
        st_be   = 4'b0000;
        st_data = wd;
        st_mis  = 1'b0;
        case (st_op)
            ST_SW: begin
                st_be   = 4'b1111;
                st_data = wd;
                st_mis  = (byte_off != 2'b00);
            end
            ST_SH: begin
                st_be   = byte_off[1] ? 4'b1100 : 4'b0011;
                st_data = {wd[15:0], wd[15:0]};
                st_mis  = byte_off[0];
            end
            ST_SB: begin
                st_be   = 4'b0001 << byte_off;
                st_data = {4{wd[7:0]}};
                st_mis  = 1'b0;
            end
            default: begin
                st_be   = 4'b0000;
                st_data = wd;
                st_mis  = 1'b0;
            end
        endcase
    end

    // Load misalignment. Byte loads and the unchecked op codes never flag.
    logic ld_mis;

    // Flag word and halfword loads whose offset does not fit their size.
    always_comb begin
        ld_mis = 1'b0;
        case (ld_op)
            LD_LW:         ld_mis = (byte_off != 2'b00);
            LD_LHU, LD_LH: ld_mis = byte_off[0];
            default:       ld_mis = 1'b0;
        endcase
    end

    // Accesses are only accepted while the memory is available.
    logic       st_acc;
    logic       ld_acc;
    logic [3:0] st_be_eff;
    logic       align_next;

    assign st_acc     = (st_op != ST_NONE) && !busy;
    assign ld_acc     = ld_en && !busy;
    // A misaligned store is dropped as a whole, not trimmed to legal lanes.
    assign st_be_eff  = (st_acc && !st_mis) ? st_be : 4'b0000;
    assign align_next = (st_acc && st_mis) || (ld_acc && ld_mis);

    // Write port selection: the clear walk owns the port while busy.
    logic [ADDR_W-1:0] wr_idx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

`ifdef DM_CLEAR_EN
    localparam logic [0:0]        FSM_CLEAR = 1'b0;
    localparam logic [0:0]        FSM_READY = 1'b1;
    localparam logic [ADDR_W-1:0] CNT_LAST  = {ADDR_W{1'b1}};

    logic [0:0]        state_reg;
    logic [0:0]        state_next;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic [ADDR_W-1:0] clr_cnt_next;

    // Walk the counter over every word, then leave CLEAR for good.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (state_reg == FSM_CLEAR) begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == CNT_LAST) begin
                state_next = FSM_READY;
            end
        end
    end

    // Clear state and counter; reset always restarts a full walk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= FSM_CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    assign busy    = (state_reg == FSM_CLEAR);
    assign wr_idx  = busy ? clr_cnt_reg : word_idx;
    assign wr_be   = busy ? 4'b1111 : st_be_eff;
    assign wr_data = busy ? 32'h0000_0000 : st_data;
`else
    assign busy    = 1'b0;
    assign wr_idx  = word_idx;
    assign wr_be   = st_be_eff;
    assign wr_data = st_data;
`endif

    // Storage: one 8-bit array per byte lane. Each lane has its own write
    // enable and a plain registered read, so the read sees the pre-store
    // contents when a load and a store hit the same word (read-first).
    logic [31:0] lane_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];

            // Commit this lane of the store or the clear walk.
            always_ff @(posedge clk) begin
                if (wr_be[gi]) begin
                    mem[wr_idx] <= wr_data[8*gi +: 8];
                end
            end

            // Registered lane read; holds its value between loads.
            always_ff @(posedge clk) begin
                if (ld_acc) begin
                    lane_q[8*gi +: 8] <= mem[word_idx];
                end
            end
        end
    endgenerate

    // Load side-band and status registers, aligned with lane_q.
    logic       rd_seen_reg;
    logic [2:0] ext_op_reg;
    logic [1:0] ext_a_reg;
    logic       ld_valid_reg;
    logic       align_err_reg;

    // Capture op/offset with each load and pulse valid/error for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_seen_reg   <= 1'b0;
            ext_op_reg    <= 3'b000;
            ext_a_reg     <= 2'b00;
            ld_valid_reg  <= 1'b0;
            align_err_reg <= 1'b0;
        end else begin
            ld_valid_reg  <= ld_acc;
            align_err_reg <= align_next;
            if (ld_acc) begin
                rd_seen_reg <= 1'b1;
                ext_op_reg  <= ld_op;
                ext_a_reg   <= byte_off;
            end
        end
    end

    // The lane registers carry no reset so they stay block-RAM friendly;
    // rd_data reads as zero until the first load after reset lands.
    assign rd_data   = rd_seen_reg ? lane_q : 32'h0000_0000;
    assign ext_op    = ext_op_reg;
    assign ext_a     = ext_a_reg;
    assign ld_valid  = ld_valid_reg;
    assign align_err = align_err_reg;

endmodule

// File: tb/tb_dm_be_ram.sv
// tb_dm_be_ram: table-driven check of dm_be_ram with a scoreboard queue.
// Inputs change on the falling edge; outputs are checked on the next falling
// edge, after the rising edge that consumed them.
module tb_dm_be_ram;

    localparam int AW = 4;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  st_op;
    logic        ld_en;
    logic [2:0]  ld_op;
    logic [31:0] rd_data;
    logic [2:0]  ext_op;
    logic [1:0]  ext_a;
    logic        ld_valid;
    logic        align_err;
    logic        busy;

    dm_be_ram #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wd        (wd),
        .st_op     (st_op),
        .ld_en     (ld_en),
        .ld_op     (ld_op),
        .rd_data   (rd_data),
        .ext_op    (ext_op),
        .ext_a     (ext_a),
        .ld_valid  (ld_valid),
        .align_err (align_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  st;
        logic        ld;
        logic [2:0]  op;
        logic        ev;
        logic [31:0] erd;
        logic        ee;
    } vec_t;

    typedef struct {
        int          id;
        logic        ev;
        logic [31:0] erd;
        logic [2:0]  eop;
        logic [1:0]  ea;
        logic        ee;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[25];
    int   n_vec = 0;
    int   n_err = 0;

`ifdef DM_CLEAR_EN
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam logic EXP_BUSY = 1'b0;
`endif

    function automatic vec_t mkv(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] s, input logic l,
                                 input logic [2:0] o, input logic ev,
                                 input logic [31:0] erd, input logic ee);
        vec_t v;
        v.addr = a; v.wd = d; v.st = s; v.ld = l; v.op = o;
        v.ev = ev; v.erd = erd; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic check_pending();
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            $display("vec %0d: ld_valid=%0b rd_data=%h ext_op=%0d ext_a=%0d align_err=%0b",
                     e.id, ld_valid, rd_data, ext_op, ext_a, align_err);
            chk($sformatf("vec%0d ld_valid", e.id), {31'b0, ld_valid}, {31'b0, e.ev});
            chk($sformatf("vec%0d align_err", e.id), {31'b0, align_err}, {31'b0, e.ee});
            if (e.ev) begin
                chk($sformatf("vec%0d rd_data", e.id), rd_data, e.erd);
                chk($sformatf("vec%0d ext_op", e.id), {29'b0, ext_op}, {29'b0, e.eop});
                chk($sformatf("vec%0d ext_a", e.id), {30'b0, ext_a}, {30'b0, e.ea});
            end
        end
    endtask

    // Called on a falling edge: check the previous vector, then drive this one.
    task automatic drive_vec(input vec_t v, input int id);
        exp_t e;
        check_pending();
        addr  = v.addr;
        wd    = v.wd;
        st_op = v.st;
        ld_en = v.ld;
        ld_op = v.op;
        e.id  = id;
        e.ev  = v.ev;
        e.erd = v.erd;
        e.eop = v.op;
        e.ea  = v.addr[1:0];
        e.ee  = v.ee;
        sbq.push_back(e);
    endtask

    task automatic idle_inputs();
        addr = 32'h0; wd = 32'h0; st_op = 2'b00; ld_en = 1'b0; ld_op = 3'b000;
    endtask

    task automatic flush();
        @(negedge clk);
        idle_inputs();
        check_pending();
    endtask

    task automatic check_reset_outputs(input string tag);
        $display("%s: rd_data=%h ext_op=%0d ext_a=%0d ld_valid=%0b align_err=%0b busy=%0b",
                 tag, rd_data, ext_op, ext_a, ld_valid, align_err, busy);
        chk({tag, " rd_data"}, rd_data, 32'h0);
        chk({tag, " ext_op"}, {29'b0, ext_op}, 32'h0);
        chk({tag, " ext_a"}, {30'b0, ext_a}, 32'h0);
        chk({tag, " ld_valid"}, {31'b0, ld_valid}, 32'h0);
        chk({tag, " align_err"}, {31'b0, align_err}, 32'h0);
        chk({tag, " busy"}, {31'b0, busy}, {31'b0, EXP_BUSY});
    endtask

`ifdef DM_CLEAR_EN
    // Called at the falling edge where reset is released.
    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        $display("%s: busy lasted %0d cycles", tag, n);
        chk({tag, " busy cycles"}, n, 32'd16);
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Word 2 = 0x11223344, then byte 9 = AA, then half @0xA = BEEF.
        tbl[0]  = mkv(32'h8, 32'h11223344, 2'b01, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
        tbl[1]  = mkv(32'h9, 32'h000000AA, 2'b11, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
        tbl[2]  = mkv(32'hA, 32'h0000BEEF, 2'b10, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
        tbl[3]  = mkv(32'h8, 32'h0,        2'b00, 1'b1, 3'b000, 1'b1, 32'hBEEFAA44, 1'b0);
        // Misaligned sw must leave word 0 untouched.
        tbl[4]  = mkv(32'h0, 32'h12345678, 2'b01, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
        tbl[5]  = mkv(32'h2, 32'hFFFFFFFF, 2'b01, 1'b0, 3'b000, 1'b0, 32'h0, 1'b1);
        tbl[6]  = mkv(32'h0, 32'h0,        2'b00, 1'b1, 3'b000, 1'b1, 32'h12345678, 1'b0);
        // Back-to-back loads lw @0, lb @5, lhu @6.
        tbl[7]  = mkv(32'h4, 32'h55667788, 2'b01, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
        tbl[8]  = mkv(32'h0, 32'h0,        2'b00, 1'b1, 3'b000, 1'b1, 32'h12345678, 1'b0);
        tbl[9]  = mkv(32'h5, 32'h0,        2'b00, 1'b1, 3'b010, 1'b1, 32'h55667788, 1'b0);
        tbl[10] = mkv(32'h6, 32'h0,        2'b00, 1'b1, 3'b011, 1'b1, 32'h55667788, 1'b0);
        // Misaligned lh still completes; lb at the same offset is fine.
        tbl[11] = mkv(32'h3, 32'h0,        2'b00, 1'b1, 3'b100, 1'b1, 32'h12345678, 1'b1);
        tbl[12] = mkv(32'h3, 32'h0,        2'b00, 1'b1, 3'b010, 1'b1, 32'h12345678, 1'b0);
        // Same-cycle store and load on word 1: read-first.
        tbl[13] = mkv(32'h4, 32'h00000000, 2'b01, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
        tbl[14] = mkv(32'h4, 32'hCAFEF00D, 2'b01, 1'b1, 3'b000, 1'b1, 32'h00000000, 1'b0);
        tbl[15] = mkv(32'h4, 32'h0,        2'b00, 1'b1, 3'b000, 1'b1, 32'hCAFEF00D, 1'b0);
        tbl[16] = mkv(32'h0, 32'h0,        2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
        // Upper half store, misaligned sh, byte store of lane 0.
        tbl[17] = mkv(32'hC, 32'hA5A5A5A5, 2'b01, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
        tbl[18] = mkv(32'hD, 32'h00001234, 2'b10, 1'b0, 3'b000, 1'b0, 32'h0, 1'b1);
        tbl[19] = mkv(32'hE, 32'h00001234, 2'b10, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
        tbl[20] = mkv(32'hC, 32'h0,        2'b00, 1'b1, 3'b000, 1'b1, 32'h1234A5A5, 1'b0);
        tbl[21] = mkv(32'hC, 32'hFFFFFF7F, 2'b11, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
        tbl[22] = mkv(32'hC, 32'h0,        2'b00, 1'b1, 3'b000, 1'b1, 32'h1234A57F, 1'b0);
        // Misaligned lw, and an unchecked op code passed straight through.
        tbl[23] = mkv(32'hE, 32'h0,        2'b00, 1'b1, 3'b000, 1'b1, 32'h1234A57F, 1'b1);
        tbl[24] = mkv(32'h1, 32'h0,        2'b00, 1'b1, 3'b101, 1'b1, 32'h12345678, 1'b0);

        // Reset state.
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

`ifdef DM_CLEAR_EN
        count_busy("clear");
        // Every word must read back as zero after the walk.
        for (int w = 0; w < 16; w++) begin
            @(negedge clk);
            drive_vec(mkv(w * 4, 32'h0, 2'b00, 1'b1, 3'b000, 1'b1, 32'h0, 1'b0), 100 + w);
        end
        flush();
        // Reset at clear cycle 7 restarts the full walk.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset mid-clear");
        @(negedge clk);
        reset = 1'b0;
        count_busy("clear restart");
`else
        @(negedge clk);
`endif

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive_vec(tbl[i], i);
        end
        flush();

        // Reset while a load result is on the outputs discards it.
        @(negedge clk);
        addr = 32'h8; ld_en = 1'b1; ld_op = 3'b000;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("pre-reset ld_valid", {31'b0, ld_valid}, 32'h1);
        chk("pre-reset rd_data", rd_data, 32'hBEEFAA44);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset mid-load");
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard bound so a broken DUT can never hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d checks done", n_vec);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_be_ram.md
# dm_be_ram

Word-organised data memory for the MEM stage of the pipelined CPU. It turns store size and address low bits into byte-lane enables and replicated write data, and performs a registered read. It hands the load extender a raw 32-bit word plus the registered load op and byte offset, all aligned to the MEM/WB boundary. It also flags misaligned accesses and, optionally, clears itself after reset.

## Interface
Parameters:
- ADDR_W, 10: word-address width; memory holds 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  byte address; word index = addr[ADDR_W+1:2], offset = addr[1:0], upper bits ignored.
- wd  in  32  store data, right-justified.
- st_op  in  2  00 none, 01 sw, 10 sh, 11 sb.
- ld_en  in  1  load request this cycle.
- ld_op  in  3  load extension op: 000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh.
- rd_data  out  32  raw memory word, registered.
- ext_op  out  3  registered ld_op, aligned with rd_data.
- ext_a  out  2  registered addr[1:0], aligned with rd_data.
- ld_valid  out  1  rd_data/ext_op/ext_a carry a new load result.
- align_err  out  1  one-cycle pulse: the previous cycle's access was misaligned.
- busy  out  1  memory unavailable; the pipeline must stall.

## Operation
- Byte enables, with lane 0 = bits 7:0:
  - sw: 1111.
  - sh: 0011 if addr[1]=0, 1100 if addr[1]=1.
  - sb: one-hot 1<<addr[1:0].
- Write-data lanes:
  - sw: wd.
  - sh: {wd[15:0], wd[15:0]}.
  - sb: {4{wd[7:0]}}.
- Only enabled lanes are written. Other lanes keep their contents.
- Store misalignment:
  - sw with addr[1:0]≠00.
  - sh with addr[0]=1.
  - sb is never misaligned.
  - A misaligned store is suppressed entirely (no lane written) and raises align_err.
- Load misalignment:
  - lw with addr[1:0]≠00.
  - lhu/lh with addr[0]=1.
  - Byte loads are never misaligned.
  - A misaligned load still completes: rd_data is the addressed word and ld_valid=1. align_err=1 in the same cycle.
- ld_op values 101–111 are passed through unchecked.
- If ld_en and a store hit the same word in the same cycle, the read is read-first: rd_data returns the pre-store word.
- State machine (with DM_CLEAR_EN):
  - CLEAR: a counter walks word 0..2^ADDR_W−1, writing 0 to one word per cycle.
  - READY: normal operation.
  - CLEAR → READY after the last word is written.
  - Without the macro, the block is always READY.
- While busy=1:
  - st_op and ld_en are ignored.
  - ld_valid=0 and align_err=0.

## Timing
- Reset values: rd_data=0, ext_op=000, ext_a=00, ld_valid=0, align_err=0. busy=1 with DM_CLEAR_EN, 0 without it. Clear counter=0.
- Store: the write is committed at the rising edge where st_op≠00 and busy=0. The word is readable by a load issued on the next cycle.
- Load: ld_en sampled at edge N. At edge N the block registers rd_data, ext_op, ext_a and ld_valid=1; they are valid during cycle N+1. Latency is 1 cycle, throughput 1 load per cycle.
- ld_en=0: ld_valid=0 the next cycle. rd_data, ext_op and ext_a hold their last values.
- align_err: registered in the same cycle as ld_valid, for both load and store misalignment. It pulses for one cycle per offending access.
- Clear: busy stays high for exactly 2^ADDR_W cycles after reset deasserts, then falls. The first accepted access is in the cycle busy is first 0.
- Reset asserted mid-clear: all outputs return to reset values immediately and the counter restarts at 0. The full 2^ADDR_W-cycle clear is repeated.
- Reset mid-load: the in-flight result is discarded and ld_valid=0.

## Configuration
- DM_CLEAR_EN defined:
  - The CLEAR state and counter are compiled in.
  - Memory is all-zero after reset; busy behaves as specified above.
- DM_CLEAR_EN undefined:
  - No counter is built; busy is tied to 0.
  - Memory contents after reset are unspecified (X in simulation). Only registers are reset.

## Test plan
- Reset with DM_CLEAR_EN, ADDR_W=4 → busy high for 16 cycles after release, then 0. lw of every word returns 0x00000000. Re-asserting reset at clear cycle 7 restarts a full 16-cycle busy.
- sw 0x11223344 @0x8, then sb 0xAA @0x9, then sh 0xBEEF @0xA; lw @0x8 → rd_data=0xBEEFAA44, ld_valid=1 one cycle after ld_en, ext_op=000, ext_a=00.
- Back-to-back: lw @0x0, lb @0x5, lhu @0x6 on consecutive cycles → three consecutive ld_valid cycles. ext_op/ext_a are 000/00, 010/01, 011/10, each aligned with its word.
- Misaligned store: sw 0xFFFFFFFF @0x2 with word 0 = 0x12345678 → align_err pulses once, no lane changes, and a later lw @0x0 returns 0x12345678.
- Misaligned loads: lh @0x3 → ld_valid=1, align_err=1, rd_data = word 0. lb @0x3 → align_err=0.
- Same-cycle sw 0xCAFEF00D @0x4 and lw @0x4 with old word 0x0 → rd_data=0x00000000. A following lw @0x4 → 0xCAFEF00D.
